data_mem_pipe: RTL and testbench

Parametrised, byte-addressed, little-endian data memory for the load/store stage. It accepts one load or store per cycle through a valid/ready request port and returns an in-order response a fixed `LATENCY` cycles later. Sub-word accesses use the RV32I `func3` encoding. The block detects misaligned, out-of-range and illegal accesses, and zero-clears its array after every reset before accepting traffic. It replaces the single-cycle word-indexed data memory between the ALU address path and the writeback mux.

---
 rtl/data_mem_pipe.sv | 176 +++++++++++++++++
 tb/tb_data_mem_pipe.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_pipe.sv
// Byte-addressed little-endian data memory with a fixed-latency in-order response pipe.
// The array is zero-cleared after every reset before requests are accepted.
module data_mem_pipe #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_func3,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic {
    S_INIT,
    S_RUN
  } state_e;

  state_e          state_q;
  logic [AW-1:0]   cnt_q;
  logic            ready_q;

  logic [31:0]     mem_q [DEPTH_WORDS];

  logic [AW-1:0]   widx;
  logic [1:0]      off;
  logic            is_b;
  logic            is_h;
  logic            is_w;
  logic            oor;
  logic            illegal;
  logic            misal;
  logic            err;
  logic            accept;
  logic            st_we;

  logic [3:0]      be;
  logic [31:0]     wd;
  logic [31:0]     rword;
  logic [7:0]      rbyte;
  logic [15:0]     rhalf;
  logic [31:0]     ld;
  logic [31:0]     rd0;
  logic            err0;

  logic [LATENCY-1:0]       v_q;
  logic [LATENCY-1:0][31:0] d_q;
  logic [LATENCY-1:0]       e_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_INIT;
      cnt_q   <= '0;
      ready_q <= 1'b0;
    end else begin
      unique case (state_q)
        S_INIT: begin
          cnt_q <= cnt_q + AW'(1);
          if (cnt_q == AW'(DEPTH_WORDS - 1)) begin
            state_q <= S_RUN;
            ready_q <= 1'b1;
          end
        end
        S_RUN: begin
          ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready = ready_q;
  assign accept    = req_valid & ready_q;

  assign widx = req_addr[AW+1:2];
  assign off  = req_addr[1:0];
  assign is_b = (req_func3[1:0] == 2'b00);
  assign is_h = (req_func3[1:0] == 2'b01);
  assign is_w = (req_func3[1:0] == 2'b10);

  // Anything above the array's byte span is out of range.
  assign oor     = |(req_addr >> (AW + 2));
  assign illegal = (req_func3[1] & req_func3[0])
                 | (req_func3[2] & req_func3[1])
                 | (req_we & req_func3[2]);
  assign misal   = (is_h & off[0]) | (is_w & (|off));
  assign err     = oor | illegal | misal;
  assign st_we   = accept & req_we & ~err;

  always_comb begin
    be = '0;
    wd = req_wdata;
    unique case (1'b1)
      is_b: begin
        be = 4'b0001 << off;
        wd = {4{req_wdata[7:0]}};
      end
      is_h: begin
        be = off[1] ? 4'b1100 : 4'b0011;
        wd = {2{req_wdata[15:0]}};
      end
      is_w: begin
        be = 4'b1111;
      end
      default: begin
        be = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (state_q == S_INIT) begin
      mem_q[cnt_q] <= '0;
    end else if (st_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem_q[widx][8*b +: 8] <= wd[8*b +: 8];
      end
    end
  end

  assign rword = mem_q[widx];
  assign rbyte = 8'(rword >> {off, 3'b000});
  assign rhalf = off[1] ? rword[31:16] : rword[15:0];

  always_comb begin
    ld = '0;
    unique case (1'b1)
      is_b: begin
        ld = req_func3[2] ? {24'b0, rbyte}
                          : {{24{rbyte[7]}}, rbyte};
      end
      is_h: begin
        ld = req_func3[2] ? {16'b0, rhalf}
                          : {{16{rhalf[15]}}, rhalf};
      end
      is_w: begin
        ld = rword;
      end
      default: begin
        ld = '0;
      end
    endcase
  end

  assign rd0  = (accept & ~req_we & ~err) ? ld : '0;
  assign err0 = accept & err;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= '0;
      d_q <= '0;
      e_q <= '0;
    end else begin
      v_q[0] <= accept;
      d_q[0] <= rd0;
      e_q[0] <= err0;
      for (int i = 1; i < int'(LATENCY); i++) begin
        v_q[i] <= v_q[i-1];
        d_q[i] <= d_q[i-1];
        e_q[i] <= e_q[i-1];
      end
    end
  end

  assign rsp_valid = v_q[LATENCY-1];
  assign rsp_rdata = d_q[LATENCY-1];
  assign rsp_err   = e_q[LATENCY-1];

endmodule

// File: tb/tb_data_mem_pipe.sv
// Randomised bench for data_mem_pipe against a byte-array reference model.
// Directed requests also carry hand-computed literal expectations.
module tb_data_mem_pipe;

  localparam int DW  = 16;
  localparam int LAT = 2;
  localparam int NB  = 4 * DW;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_func3 = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  data_mem_pipe #(
    .DEPTH_WORDS(DW),
    .LATENCY(LAT)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_we(req_we),
    .req_addr(req_addr),
    .req_wdata(req_wdata),
    .req_func3(req_func3),
    .rsp_valid(rsp_valid),
    .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  byte unsigned bm [NB];

  typedef struct {
    int          due;
    logic [31:0] rd;
    logic        er;
    bit          lit;
    logic [31:0] lrd;
    logic        ler;
  } exp_t;

  exp_t q [$];

  function automatic void chk(input string nm,
                              input logic [31:0] act,
                              input logic [31:0] want);
    n_cmp++;
    if (act !== want) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", nm, act, want, cyc);
    end
  endfunction

  function automatic void model(input logic we, input logic [31:0] a,
                                input logic [31:0] wd, input logic [2:0] f3,
                                output logic [31:0] rd, output logic er);
    int sz;
    bit legal;
    logic [31:0] v;
    legal = (f3 == 3'd0) || (f3 == 3'd1) || (f3 == 3'd2) ||
            (f3 == 3'd4) || (f3 == 3'd5);
    sz = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    er = !legal || (we && f3[2]) || (a >= 32'(NB)) || ((a % sz) != 0);
    rd = '0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < sz; i++) bm[a + i] = wd[8*i +: 8];
      end else begin
        v = '0;
        for (int i = 0; i < sz; i++) v = v | (32'(bm[a + i]) << (8 * i));
        if (!f3[2] && sz < 4 && v[8*sz-1]) v = v | (32'hffffffff << (8 * sz));
        rd = v;
      end
    end
  endfunction

  task automatic issue(input logic we, input logic [31:0] a,
                       input logic [31:0] wd, input logic [2:0] f3,
                       input bit lit = 1'b0,
                       input logic [31:0] lrd = '0,
                       input logic ler = 1'b0);
    exp_t e;
    chk("req_ready", {31'b0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = wd;
    req_func3 = f3;
    model(we, a, wd, f3, e.rd, e.er);
    e.due = cyc + LAT;
    e.lit = lit;
    e.lrd = lrd;
    e.ler = ler;
    q.push_back(e);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q.delete();
    foreach (bm[i]) bm[i] = 8'h00;
    chk_en = 1'b1;
    #1;
    chk("rst_ready", {31'b0, req_ready}, 32'd0);
    chk("rst_valid", {31'b0, rsp_valid}, 32'd0);
    chk("rst_rdata", rsp_rdata, 32'd0);
    chk("rst_err", {31'b0, rsp_err}, 32'd0);
    idle(2);
    rst_n = 1'b1;
    for (int i = 1; i <= DW; i++) begin
      @(posedge clk);
      #1;
      chk("init_ready", {31'b0, req_ready}, (i == DW) ? 32'd1 : 32'd0);
    end
  endtask

  always @(negedge clk) begin : compare
    exp_t e;
    if (chk_en) begin
      if (q.size() > 0 && q[0].due == cyc) begin
        e = q.pop_front();
        chk("rsp_valid", {31'b0, rsp_valid}, 32'd1);
        chk("rsp_rdata", rsp_rdata, e.rd);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, e.er});
        if (e.lit) begin
          chk("lit_rdata", rsp_rdata, e.lrd);
          chk("lit_err", {31'b0, rsp_err}, {31'b0, e.ler});
        end
      end else begin
        chk("idle_valid", {31'b0, rsp_valid}, 32'd0);
        chk("idle_rdata", rsp_rdata, 32'd0);
        chk("idle_err", {31'b0, rsp_err}, 32'd0);
      end
    end
  end

  initial begin
    logic [31:0] d;
    logic [31:0] a;
    #2;
    do_reset();

    for (int i = 0; i < DW; i++) issue(0, 32'(4 * i), '0, 3'b010, 1, 32'h0, 0);
    idle(3);

    issue(1, 32'h10, 32'h8badf00d, 3'b010, 1, 32'h0, 0);
    issue(0, 32'h10, '0, 3'b010, 1, 32'h8badf00d, 0);

    issue(1, 32'h21, 32'h000000ab, 3'b000, 1, 32'h0, 0);
    issue(0, 32'h21, '0, 3'b000, 1, 32'hffffffab, 0);
    issue(0, 32'h21, '0, 3'b100, 1, 32'h000000ab, 0);
    issue(0, 32'h20, '0, 3'b010, 1, 32'h0000ab00, 0);
    issue(1, 32'h22, 32'h00008001, 3'b001, 1, 32'h0, 0);
    issue(0, 32'h22, '0, 3'b001, 1, 32'hffff8001, 0);
    idle(2);

    issue(0, 32'h12, '0, 3'b010, 1, 32'h0, 1);
    issue(1, 32'h13, 32'h0000ffff, 3'b001, 1, 32'h0, 1);
    issue(0, 32'h10, '0, 3'b010, 1, 32'h8badf00d, 0);
    issue(0, 32'h40, '0, 3'b010, 1, 32'h0, 1);
    issue(0, 32'h00, '0, 3'b011, 1, 32'h0, 1);
    issue(1, 32'h30, 32'h00000055, 3'b100, 1, 32'h0, 1);
    issue(0, 32'h30, '0, 3'b010, 1, 32'h0, 0);
    idle(2);

    for (int i = 0; i < 4; i++) begin
      d = $urandom;
      issue(1, 32'(4 * (10 + i)), d, 3'b010, 1, 32'h0, 0);
      issue(0, 32'(4 * (10 + i)), '0, 3'b010, 1, d, 0);
    end
    idle(3);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(9) == 0) a = $urandom;
      else a = 32'($urandom_range(NB + 3));
      issue(logic'($urandom_range(1)), a, $urandom, 3'($urandom_range(7)));
      if ($urandom_range(3) == 0) idle(1);
    end
    idle(3);

    issue(1, 32'h3c, 32'h12345678, 3'b010, 1, 32'h0, 0);
    issue(0, 32'h3c, '0, 3'b010);
    issue(0, 32'h38, '0, 3'b010);
    do_reset();
    issue(0, 32'h3c, '0, 3'b010, 1, 32'h0, 0);
    idle(2);

    for (int n = 0; n < 100; n++) begin
      a = 32'($urandom_range(NB - 1));
      issue(logic'($urandom_range(1)), a, $urandom, 3'($urandom_range(5)));
    end

    idle(LAT + 2);
    chk("drain", q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
